// File: rtl/alu_pkg.sv
// Shared ALU opcodes and multiplier FSM encoding.
// The ALU decoder and the hazard unit use the same definitions.
package alu_pkg;

   localparam logic [2:0] ALU_ADD   = 3'b000;
   localparam logic [2:0] ALU_SUB   = 3'b001;
   localparam logic [2:0] ALU_AND   = 3'b010;
   localparam logic [2:0] ALU_OR    = 3'b011;
   localparam logic [2:0] ALU_MUL   = 3'b100;
   localparam logic [2:0] ALU_SLT   = 3'b101;
   localparam logic [2:0] ALU_PASSB = 3'b110;

   typedef enum logic [1:0] {
      MUL_IDLE = 2'd0,
      MUL_BUSY = 2'd1,
      MUL_DONE = 2'd2
   } mul_state_t;

endpackage

// File: rtl/iter_multiplier.sv
// Iterative shift-add multiplier retiring MUL_STEP bits of b per cycle.
// Produces the low WIDTH bits of a*b, one DONE cycle after the last iteration.
module iter_multiplier
   import alu_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int MUL_STEP = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic             abort,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] product
);

   localparam int N  = WIDTH / MUL_STEP;
   localparam int CW = $clog2(N + 1);

   mul_state_t       state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] partial;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= MUL_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         MUL_IDLE: if (start) state_d = MUL_BUSY;
         MUL_BUSY: begin
            if (abort)                        state_d = MUL_IDLE;
            else if (cnt_q == CW'(N - 1))     state_d = MUL_DONE;
         end
         MUL_DONE: state_d = MUL_IDLE;
         default:  state_d = MUL_IDLE;
      endcase
   end

   // Partial product of the low MUL_STEP bits of b against the pre-shifted a.
   always_comb begin
      partial = '0;
      for (int i = 0; i < MUL_STEP; i++) begin
         if (b_q[i]) partial = partial + (a_q << i);
      end
   end

   always_comb begin
      a_d   = a_q;
      b_d   = b_q;
      acc_d = acc_q;
      cnt_d = cnt_q;
      if (state_q == MUL_IDLE && start) begin
         a_d   = a;
         b_d   = b;
         acc_d = '0;
         cnt_d = '0;
      end else if (state_q == MUL_BUSY) begin
         acc_d = acc_q + partial;
         a_d   = a_q << MUL_STEP;
         b_d   = b_q >> MUL_STEP;
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_comb begin
      busy = (state_q == MUL_BUSY);
      done = (state_q == MUL_DONE);
   end

   assign product = acc_q;

endmodule

// File: rtl/execute_alu_unit.sv
// Execute-stage ALU: single-cycle ops combinationally, MUL via iter_multiplier
// with StallE held to the hazard unit until the product is presented.
module execute_alu_unit
   import alu_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int MUL_STEP = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             ValidE,
   input  logic             FlushE,
   input  logic [2:0]       ALUControl,
   input  logic [WIDTH-1:0] SrcAE,
   input  logic [WIDTH-1:0] SrcBE,
   output logic [WIDTH-1:0] ALUResultE,
   output logic             ZeroE,
   output logic             StallE,
   output logic             MulBusy
);

   logic             mul_start;
   logic             mul_busy;
   logic             mul_done;
   logic [WIDTH-1:0] mul_product;
   logic [WIDTH-1:0] diff;
   logic             ovf;
   logic             lt;
   logic [WIDTH-1:0] alu_comb;

   assign mul_start = ValidE & ~FlushE & (ALUControl == ALU_MUL) & ~mul_busy & ~mul_done;

   iter_multiplier #(
      .WIDTH    (WIDTH),
      .MUL_STEP (MUL_STEP)
   ) u_mul (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (mul_start),
      .abort   (FlushE),
      .a       (SrcAE),
      .b       (SrcBE),
      .busy    (mul_busy),
      .done    (mul_done),
      .product (mul_product)
   );

   // Signed less-than from the subtractor: sign of A-B corrected by overflow.
   always_comb begin
      diff = SrcAE - SrcBE;
      ovf  = (SrcAE[WIDTH-1] ^ SrcBE[WIDTH-1]) & (diff[WIDTH-1] ^ SrcAE[WIDTH-1]);
      lt   = diff[WIDTH-1] ^ ovf;
   end

   always_comb begin
      alu_comb = '0;
      case (ALUControl)
         ALU_ADD:   alu_comb = SrcAE + SrcBE;
         ALU_SUB:   alu_comb = diff;
         ALU_AND:   alu_comb = SrcAE & SrcBE;
         ALU_OR:    alu_comb = SrcAE | SrcBE;
         ALU_SLT:   alu_comb = {{(WIDTH-1){1'b0}}, lt};
         ALU_PASSB: alu_comb = SrcBE;
         ALU_MUL:   alu_comb = mul_product;
         default:   alu_comb = '0;
      endcase
   end

   assign ALUResultE = mul_done ? mul_product : alu_comb;
   assign ZeroE      = (ALUResultE == '0);
   // The issue-cycle stall is combinational, so it is gated to drop during reset.
   assign StallE     = (mul_start & reset_n) | mul_busy;
   assign MulBusy    = mul_busy | mul_done;

endmodule
